// File: rtl/hilo_issue_ctrl_pkg.sv
// Shared HI/LO op codes and busy-tracker state encoding; codes match the E-stage HI/LO unit.
package hilo_defs;

  localparam logic [3:0] HL_none  = 4'd0;
  localparam logic [3:0] HL_mult  = 4'd1;
  localparam logic [3:0] HL_multu = 4'd2;
  localparam logic [3:0] HL_div   = 4'd3;
  localparam logic [3:0] HL_divu  = 4'd4;
  localparam logic [3:0] HL_mflo  = 4'd5;
  localparam logic [3:0] HL_mfhi  = 4'd6;
  localparam logic [3:0] HL_mtlo  = 4'd7;
  localparam logic [3:0] HL_mthi  = 4'd8;

  typedef enum logic [1:0] {IDLE, BUSY_MUL, BUSY_DIV} hl_state_t;

  function automatic logic is_hilo(input logic [3:0] op);
    return op inside {HL_mult, HL_multu, HL_div, HL_divu, HL_mflo, HL_mfhi, HL_mtlo, HL_mthi};
  endfunction

  function automatic logic is_start(input logic [3:0] op);
    return op inside {HL_mult, HL_multu, HL_div, HL_divu};
  endfunction

endpackage

// File: rtl/hilo_issue_ctrl_if.sv
// D/E-stage HILO issue signals; master drives the decoded op and hazard inputs.
interface hilo_issue_ctrl_if;
  logic [3:0]  d_op;
  logic        hz_stall;
  logic        flush_e;
  logic        md_busy;
  logic        stall_d;
  logic [3:0]  e_op;
  logic [31:0] stall_cnt;
  logic        chk_err;

  modport master (output d_op, hz_stall, flush_e, md_busy,
                  input  stall_d, e_op, stall_cnt, chk_err);
  modport slave  (input  d_op, hz_stall, flush_e, md_busy,
                  output stall_d, e_op, stall_cnt, chk_err);
endinterface

// File: rtl/hilo_busy_tracker.sv
// Cycle-exact mirror of the HI/LO unit countdown; busy is combinational from registered state only.
module hilo_busy_tracker
  import hilo_defs::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] e_op,
  output logic       mirror_busy
);

  hl_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (e_op == HL_mult || e_op == HL_multu) begin
          state_d = BUSY_MUL;
          cnt_d   = CNT_W'(MULT_LAT);
        end else if (e_op == HL_div || e_op == HL_divu) begin
          state_d = BUSY_DIV;
          cnt_d   = CNT_W'(DIV_LAT);
        end
      end
      BUSY_MUL, BUSY_DIV: begin
        // The unit commits HI/LO on the edge where the count leaves 1.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign mirror_busy = is_start(e_op) || (cnt_q != '0);

endmodule

// File: rtl/hilo_issue_ctrl.sv
// HILO op D-stage hold and E-stage issue (1-cycle D->E); stall_d holds D while the unit is busy.
// Optional busy cross-check against the real unit is enabled with HILO_CHECK_EN.
module hilo_issue_ctrl
  import hilo_defs::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input logic               clk,
  input logic               reset,
  hilo_issue_ctrl_if.slave  bus
);

  logic        mirror_busy;
  logic        hl_stall;
  logic        stall;
  logic [3:0]  e_op_q;
  logic [31:0] stall_cnt_q;

  hilo_busy_tracker #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_tracker (
    .clk         (clk),
    .reset       (reset),
    .e_op        (e_op_q),
    .mirror_busy (mirror_busy)
  );

  assign hl_stall = is_hilo(bus.d_op) && mirror_busy;
  assign stall    = hl_stall || bus.hz_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_op_q      <= HL_none;
      stall_cnt_q <= '0;
    end else begin
      e_op_q <= (bus.flush_e || stall) ? HL_none : bus.d_op;
      // Only stalls owed purely to the HI/LO unit are counted.
      if (hl_stall && !bus.hz_stall)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall_d   = stall;
  assign bus.e_op      = e_op_q;
  assign bus.stall_cnt = stall_cnt_q;

`ifdef HILO_CHECK_EN
  logic chk_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      chk_err_q <= 1'b0;
    end else if (bus.md_busy != mirror_busy) begin
      chk_err_q <= 1'b1;
`ifndef SYNTHESIS
      $display("hilo_issue_ctrl: md_busy=%0b disagrees with mirror_busy=%0b at %0t",
               bus.md_busy, mirror_busy, $time);
`endif
    end
  end

  assign bus.chk_err = chk_err_q;
`else
  logic md_busy_unused;
  assign md_busy_unused = bus.md_busy;
  assign bus.chk_err    = 1'b0;
`endif

endmodule
